alu_exec_stage: RTL and testbench

//  Registered ALU execute stage, directly downstream of the 3->8 opcode decoder.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_seq.sv | 52 +++++
 rtl/alu_exec_stage.sv | 120 ++++++++++++
 tb/tb_alu_exec_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage.
// Op select bit positions and FSM state encoding.
package alu_pkg;

    localparam int NUM_OPS = 8;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_NOTA = 5;
    localparam int OP_SHL  = 6;
    localparam int OP_MUL  = 7;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle.
// done and prod are combinational on the final step so the caller can load them that edge.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);

    logic               busy;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    assign partial = mplier[0] ? mcand : '0;
    assign prod    = acc + partial;
    assign done    = busy && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            count  <= '0;
        end else if (busy) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage fed by a one-hot op decoder.
// Single-cycle ops land in the output register at accept; MUL goes through alu_mul_seq.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_OPS-1:0] op_sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    alu_state_t         state;
    logic               sel_ok;
    logic               is_mul;
    logic               accept;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res_n;
    logic               cy_n;

    assign sel_ok = $onehot(op_sel);
    assign is_mul = sel_ok && op_sel[OP_MUL];
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};

    // Gated by reset_n so the stage advertises nothing while held in reset.
    assign in_ready = reset_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        res_n = '0;
        cy_n  = 1'b0;
        if (sel_ok) begin
            unique case (1'b1)
                op_sel[OP_ADD]: begin
                    res_n = sum[WIDTH-1:0];
                    cy_n  = sum[WIDTH];
                end
                op_sel[OP_SUB]: begin
                    res_n = diff[WIDTH-1:0];
                    cy_n  = diff[WIDTH];
                end
                op_sel[OP_AND]:  res_n = a & b;
                op_sel[OP_OR]:   res_n = a | b;
                op_sel[OP_XOR]:  res_n = a ^ b;
                op_sel[OP_NOTA]: res_n = ~a;
                op_sel[OP_SHL]: begin
                    res_n = {a[WIDTH-2:0], 1'b0};
                    cy_n  = a[WIDTH-1];
                end
                default: res_n = '0;
            endcase
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .prod    (mul_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state <= MUL_BUSY;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                        result    <= res_n;
                        carry     <= cy_n;
                        zero      <= (res_n == '0);
                        err       <= !sel_ok;
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        result    <= mul_prod[WIDTH-1:0];
                        carry     <= |mul_prod[2*WIDTH-1:WIDTH];
                        zero      <= (mul_prod[WIDTH-1:0] == '0);
                        err       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage at WIDTH=8.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_alu_exec_stage;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       err;

    int checks;
    int failures;

    alu_exec_stage #(
        .WIDTH(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        op_sel   = op;
        a        = x;
        b        = y;
        step();
        in_valid = 1'b0;
        op_sel   = 8'h00;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        op_sel    = 8'h00;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b0;
        #3;
        checks++;
        if ({out_valid, result, carry, zero, err, in_ready} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs got ov=%b r=%h c=%b z=%b e=%b ir=%b want all 0",
                     out_valid, result, carry, zero, err, in_ready);
        end
        step();
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_pre_valid got %b want 0", out_valid);
        end
        issue(8'h01, 8'hF0, 8'h20);
        checks++;
        if ({out_valid, result, carry, zero, err} !== {1'b1, 8'h10, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add got ov=%b r=%h c=%b z=%b e=%b want ov=1 r=10 c=1 z=0 e=0",
                     out_valid, result, carry, zero, err);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_drain got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        issue(8'h02, 8'h05, 8'h05);
        checks++;
        if ({out_valid, result, carry, zero} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sub_equal got ov=%b r=%h c=%b z=%b want ov=1 r=00 c=0 z=1",
                     out_valid, result, carry, zero);
        end
        issue(8'h02, 8'h03, 8'h05);
        checks++;
        if ({out_valid, result, carry, zero} !== {1'b1, 8'hFE, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_borrow got ov=%b r=%h c=%b z=%b want ov=1 r=fe c=1 z=0",
                     out_valid, result, carry, zero);
        end
        step();
    endtask

    task automatic test_mul();
        int n;
        int busy_ready;
        out_ready  = 1'b1;
        n          = 0;
        busy_ready = 0;
        issue(8'h80, 8'h12, 8'h10);
        while (!out_valid && n < 20) begin
            if (in_ready !== 1'b0) busy_ready++;
            step();
            n++;
        end
        checks++;
        if (n + 1 != 9) begin
            failures++;
            $display("FAIL mul_latency got %0d want 9", n + 1);
        end
        checks++;
        if (busy_ready != 0) begin
            failures++;
            $display("FAIL mul_in_ready got %0d busy cycles with in_ready!=0 want 0", busy_ready);
        end
        checks++;
        if ({out_valid, result, carry, zero, err} !== {1'b1, 8'h20, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mul got ov=%b r=%h c=%b z=%b e=%b want ov=1 r=20 c=1 z=0 e=0",
                     out_valid, result, carry, zero, err);
        end
        issue(8'h80, 8'h0B, 8'h0D);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if ({out_valid, result, carry} !== {1'b1, 8'h8F, 1'b0}) begin
            failures++;
            $display("FAIL mul_small got ov=%b r=%h c=%b want ov=1 r=8f c=0",
                     out_valid, result, carry);
        end
        step();
    endtask

    task automatic test_invalid();
        out_ready = 1'b1;
        issue(8'h00, 8'hFF, 8'hFF);
        checks++;
        if ({out_valid, result, carry, zero, err} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL invalid_none got ov=%b r=%h c=%b z=%b e=%b want ov=1 r=00 c=0 z=1 e=1",
                     out_valid, result, carry, zero, err);
        end
        issue(8'h03, 8'hFF, 8'hFF);
        checks++;
        if ({out_valid, result, carry, zero, err} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL invalid_multi got ov=%b r=%h c=%b z=%b e=%b want ov=1 r=00 c=0 z=1 e=1",
                     out_valid, result, carry, zero, err);
        end
        step();
    endtask

    task automatic test_backpressure();
        int bad;
        bad       = 0;
        out_ready = 1'b0;
        issue(8'h10, 8'hA5, 8'h0F);
        checks++;
        if ({out_valid, result, carry, err} !== {1'b1, 8'hAA, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL bp_xor got ov=%b r=%h c=%b e=%b want ov=1 r=aa c=0 e=0",
                     out_valid, result, carry, err);
        end
        in_valid = 1'b1;
        op_sel   = 8'h01;
        a        = 8'h01;
        b        = 8'h01;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 8'hAA) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        op_sel   = 8'h00;
        checks++;
        if ({out_valid, result, carry} !== {1'b1, 8'h02, 1'b0}) begin
            failures++;
            $display("FAIL bp_replace got ov=%b r=%h c=%b want ov=1 r=02 c=0",
                     out_valid, result, carry);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops  [5] = '{8'h04, 8'h08, 8'h20, 8'h40, 8'h01};
        logic [7:0] va   [5] = '{8'hCC, 8'hCC, 8'h0F, 8'h81, 8'h01};
        logic [7:0] vb   [5] = '{8'hAA, 8'hAA, 8'h33, 8'h00, 8'h02};
        logic [7:0] er   [5] = '{8'h88, 8'hEE, 8'hF0, 8'h02, 8'h03};
        logic       ec   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op_sel   = ops[i];
            a        = va[i];
            b        = vb[i];
            step();
            checks++;
            if ({out_valid, result, carry, in_ready} !== {1'b1, er[i], ec[i], 1'b1}) begin
                failures++;
                $display("FAIL b2b_%0d got ov=%b r=%h c=%b ir=%b want ov=1 r=%h c=%b ir=1",
                         i, out_valid, result, carry, in_ready, er[i], ec[i]);
            end
        end
        in_valid = 1'b0;
        op_sel   = 8'h00;
        step();
    endtask

    task automatic test_reset_mid();
        int stale;
        stale     = 0;
        out_ready = 1'b1;
        issue(8'h80, 8'h12, 8'h10);
        step();
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, result, carry, zero, err, in_ready} !== 13'h0) begin
            failures++;
            $display("FAIL midreset_outputs got ov=%b r=%h c=%b z=%b e=%b ir=%b want all 0",
                     out_valid, result, carry, zero, err, in_ready);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready got %b want 1", in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) stale++;
            step();
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL midreset_stale got %0d valid cycles want 0", stale);
        end
        issue(8'h01, 8'h02, 8'h03);
        checks++;
        if ({out_valid, result, carry, zero} !== {1'b1, 8'h05, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_add got ov=%b r=%h c=%b z=%b want ov=1 r=05 c=0 z=0",
                     out_valid, result, carry, zero);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_invalid();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
